exp_sched: RTL and testbench

Round-robin scheduler that shares one `exp` pipeline among `NUM_REQ` attention-score requesters, e.g. parallel softmax rows. It arbitrates issue into the unit and tracks every in-flight element with a tag pipeline. Results are routed back to their owner, and each requester gets a running sum of its exp values that is emitted at end of row (softmax denominator). It sits between the score buffers and the `exp` instance; the constant operands (`qb`, `qc`, `qln2`, `qln2_inv`) are wired to `exp` directly at top level.

---
 rtl/exp_sched_pkg.sv | 18 +
 rtl/exp_sched_arb.sv | 48 ++++
 rtl/exp_sched.sv | 125 ++++++++++++
 tb/tb_exp_sched.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exp_sched_pkg.sv
// rtl/exp_sched_pkg.sv - shared types and default parameters for the exp scheduler
// Provides the tag carried alongside every element in flight through exp.
package exp_sched_pkg;

  localparam int NUM_REQ_DEFAULT = 4;
  localparam int EXP_LAT_DEFAULT = 8;
  localparam int SUM_W_DEFAULT   = 48;

  // Tag id width is fixed here, so NUM_REQ must not exceed 2**ID_W.
  localparam int ID_W = $clog2(NUM_REQ_DEFAULT);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic            last;
  } tag_t;

endpackage

// File: rtl/exp_sched_arb.sv
// rtl/exp_sched_arb.sv - round-robin arbiter with advance-on-accept pointer
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   req             request vector
//   accept          a grant was taken this cycle; pointer moves past the winner
//   grant           one-hot grant, combinational from req and the pointer
//   grant_id        index of the granted requester
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int PW = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant,
  output logic [PW-1:0]      grant_id
);

  logic [PW-1:0] ptr;
  int            idx;

  // Scan from the highest priority offset downwards so the last write is the
  // first valid requester at or after ptr.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    idx      = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_id   = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (grant_id == PW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/exp_sched.sv
// rtl/exp_sched.sv - round-robin scheduler sharing one exp pipeline among requesters
// Ports:
//   clk, rst                           clock, asynchronous active-low reset
//   req_valid/req_last/req_qin/req_ready  per-requester score input and grant
//   exp_in_valid/exp_qin               issue port to exp
//   exp_out_valid/exp_qout             result port from exp
//   rsp_valid/rsp_data/rsp_last        per-requester routed result
//   sum_valid/sum_data                 per-requester row sum at end of row
//   busy                               any element in flight
//   tag_err                            sticky: exp result and tag pipe disagree
module exp_sched
  import exp_sched_pkg::*;
#(
  parameter int D_W     = 32,
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int EXP_LAT = EXP_LAT_DEFAULT,
  parameter int SUM_W   = SUM_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_last,
  input  logic [NUM_REQ*D_W-1:0] req_qin,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   exp_in_valid,
  output logic [D_W-1:0]         exp_qin,
  input  logic                   exp_out_valid,
  input  logic [D_W-1:0]         exp_qout,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [D_W-1:0]         rsp_data,
  output logic                   rsp_last,
  output logic [NUM_REQ-1:0]     sum_valid,
  output logic [SUM_W-1:0]       sum_data,
  output logic                   busy,
  output logic                   tag_err
);

  localparam int PW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] grant;
  logic [PW-1:0]      win;
  logic               xfer;

  assign xfer      = |grant;
  assign req_ready = grant;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req_valid),
    .accept   (xfer),
    .grant    (grant),
    .grant_id (win)
  );

  // The issue register holds the tag for the element exp is sampling this
  // cycle; tag_pipe then mirrors the EXP_LAT stages inside exp.
  tag_t             iss_tag;
  tag_t             tag_pipe [EXP_LAT];
  tag_t             tail;
  logic [SUM_W-1:0] acc [NUM_REQ];
  logic [SUM_W-1:0] q_ext;
  logic             retire;

  assign tail   = tag_pipe[EXP_LAT-1];
  assign q_ext  = {{(SUM_W - D_W){exp_qout[D_W-1]}}, exp_qout};
  assign retire = exp_out_valid & tail.valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_in_valid <= 1'b0;
      exp_qin      <= '0;
      iss_tag      <= '0;
    end else begin
      exp_in_valid <= xfer;
      iss_tag      <= '{valid: xfer, id: ID_W'(win), last: req_last[win]};
      if (xfer) exp_qin <= req_qin[int'(win)*D_W +: D_W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < EXP_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= iss_tag;
      for (int i = 1; i < EXP_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_last  <= 1'b0;
      sum_valid <= '0;
      sum_data  <= '0;
      tag_err   <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) acc[i] <= '0;
    end else begin
      rsp_valid <= '0;
      sum_valid <= '0;
      // Either side arriving without the other means exp and the tag pipe
      // have fallen out of lockstep.
      if (exp_out_valid != tail.valid) tag_err <= 1'b1;
      if (retire) begin
        rsp_valid[tail.id] <= 1'b1;
        rsp_data           <= exp_qout;
        rsp_last           <= tail.last;
        if (tail.last) begin
          sum_valid[tail.id] <= 1'b1;
          sum_data           <= acc[tail.id] + q_ext;
          acc[tail.id]       <= '0;
        end else begin
          acc[tail.id] <= acc[tail.id] + q_ext;
        end
      end
    end
  end

  always_comb begin
    busy = iss_tag.valid;
    for (int i = 0; i < EXP_LAT; i++) busy = busy | tag_pipe[i].valid;
  end

endmodule

// File: tb/tb_exp_sched.sv
// tb/tb_exp_sched.sv - self-checking bench for exp_sched with a mock exp pipeline
module tb_exp_sched;
  localparam int D_W = 32;
  localparam int NR  = 4;
  localparam int LAT = 8;
  localparam int SW  = 48;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid, req_last, req_ready;
  logic [NR*D_W-1:0] req_qin;
  logic             exp_in_valid, exp_out_valid, rsp_last, busy, tag_err;
  logic [D_W-1:0]   exp_qin, exp_qout, rsp_data;
  logic [NR-1:0]    rsp_valid, sum_valid;
  logic [SW-1:0]    sum_data;
  logic             inj;

  always #5 clk = ~clk;

  exp_sched #(.D_W(D_W), .NUM_REQ(NR), .EXP_LAT(LAT), .SUM_W(SW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last),
    .req_qin(req_qin), .req_ready(req_ready), .exp_in_valid(exp_in_valid),
    .exp_qin(exp_qin), .exp_out_valid(exp_out_valid), .exp_qout(exp_qout),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .sum_valid(sum_valid), .sum_data(sum_data), .busy(busy), .tag_err(tag_err)
  );

  // Mock exp: fixed latency, result = qin + 2^30 (qin=0 gives 1.0 = 2^30).
  logic           mv [LAT];
  logic [D_W-1:0] md [LAT];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) begin mv[i] <= 1'b0; md[i] <= '0; end
    end else begin
      mv[0] <= exp_in_valid;
      md[0] <= exp_qin + 32'h4000_0000;
      for (int i = 1; i < LAT; i++) begin mv[i] <= mv[i-1]; md[i] <= md[i-1]; end
    end
  end
  assign exp_out_valid = mv[LAT-1] | inj;
  assign exp_qout      = md[LAT-1];

  int tests = 0, fails = 0, n = 0;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, n);
    end
  endtask

  function automatic logic [31:0] fexp(input logic [31:0] q);
    return q + 32'd1073741824;
  endfunction

  // Model: each accepted element becomes an event; its issue, in-flight window
  // and response cycle follow from the fixed latency.
  typedef struct {
    int          issue;
    int          id;
    logic [31:0] q;
    logic [31:0] r;
    logic        last;
    logic [47:0] sum;
  } ev_t;
  ev_t         evq[$];
  ev_t         ev;
  logic [47:0] macc [NR];
  int          mptr, idx, w, tr_n, rsp_n, rsp_cnt;
  logic        mterr;
  logic [NR-1:0] e_rsp, e_sum, g;
  logic        e_in, e_busy, e_last;
  logic [31:0] e_q, e_data, last_rsp;
  logic [47:0] e_sdata;
  int          grant_log[$];
  logic [49:0] sum_log[$];

  always @(negedge clk) begin
    if (!rst) begin
      evq.delete();
      for (int i = 0; i < NR; i++) macc[i] = '0;
      mptr  = 0;
      mterr = 1'b0;
    end else begin
      n++;
      e_rsp = '0; e_sum = '0; e_in = 0; e_busy = 0; e_last = 0;
      e_q = '0; e_data = '0; e_sdata = '0;
      foreach (evq[k]) begin
        if (evq[k].issue == n) begin e_in = 1; e_q = evq[k].q; end
        if (evq[k].issue <= n && n <= evq[k].issue + LAT) e_busy = 1;
        if (evq[k].issue + LAT + 1 == n) begin
          e_rsp[evq[k].id] = 1'b1;
          e_data = evq[k].r;
          e_last = evq[k].last;
          if (evq[k].last) begin e_sum[evq[k].id] = 1'b1; e_sdata = evq[k].sum; end
        end
      end
      while (evq.size() > 0 && evq[0].issue + LAT + 1 <= n) void'(evq.pop_front());

      chk("exp_in_valid", 64'(exp_in_valid), 64'(e_in));
      if (e_in) chk("exp_qin", 64'(exp_qin), 64'(e_q));
      chk("busy", 64'(busy), 64'(e_busy));
      chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
      if (e_rsp != 0) begin
        chk("rsp_data", 64'(rsp_data), 64'(e_data));
        chk("rsp_last", 64'(rsp_last), 64'(e_last));
      end
      chk("sum_valid", 64'(sum_valid), 64'(e_sum));
      if (e_sum != 0) chk("sum_data", 64'(sum_data), 64'(e_sdata));
      chk("tag_err", 64'(tag_err), 64'(mterr));
      if (rsp_valid != 0) begin rsp_n = n; last_rsp = rsp_data; rsp_cnt++; end
      for (int i = 0; i < NR; i++)
        if (sum_valid[i]) sum_log.push_back({2'(i), sum_data});

      // Expected grant: first valid requester at or after the round-robin pointer.
      g = '0; w = 0;
      for (int i = 0; i < NR; i++) begin
        idx = (mptr + i) % NR;
        if (g == 0 && req_valid[idx]) begin g[idx] = 1'b1; w = idx; end
      end
      chk("req_ready", 64'(req_ready), 64'(g));
      if (g != 0) begin
        ev.issue = n + 1;
        ev.id    = w;
        ev.q     = req_qin[w*D_W +: D_W];
        ev.r     = fexp(ev.q);
        ev.last  = req_last[w];
        macc[w]  = macc[w] + {{16{ev.r[31]}}, ev.r};
        ev.sum   = macc[w];
        if (ev.last) macc[w] = '0;
        evq.push_back(ev);
        mptr = (w + 1) % NR;
        grant_log.push_back(w);
        tr_n = n;
      end
      if (inj) mterr = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    req_valid = '0;
    req_last  = '0;
    repeat (k) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected finish)");
    $fatal(1);
  end

  int          q1[6] = '{10, 20, 30, 40, 50, 60};
  int          q2[4] = '{-5, 7, -9, 20};
  int          exp_g[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  logic [47:0] s1[$], s2[$];
  logic [NR-1:0] gseen;
  int          i1, i2, cnt, c0;

  initial begin
    rst = 1'b0; req_valid = '0; req_last = '0; req_qin = '0; inj = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset req_ready", 64'(req_ready), 0);
    chk("reset exp_in_valid", 64'(exp_in_valid), 0);
    chk("reset rsp_valid", 64'(rsp_valid), 0);
    chk("reset sum_valid", 64'(sum_valid), 0);
    chk("reset busy", 64'(busy), 0);
    chk("reset tag_err", 64'(tag_err), 0);
    rst = 1'b1;
    tick();

    // Single element: qin=0, last=1 on r0.
    sum_log.delete();
    req_valid = 4'b0001; req_last = 4'b0001; req_qin = '0;
    tick();
    idle(14);
    chk("single rsp_data", 64'(last_rsp), 64'h4000_0000);
    chk("single latency", 64'(rsp_n - tr_n), 10);
    chk("single sum count", 64'(sum_log.size()), 1);
    if (sum_log.size() == 1) chk("single sum", 64'(sum_log[0]), {14'd0, 2'd0, 48'h4000_0000});

    // Reset pulse so the pointer starts at 0 for the fairness run.
    rst = 1'b0; tick(); rst = 1'b1; tick();

    grant_log.delete();
    req_valid = 4'hF; req_last = 4'hF;
    for (int c = 0; c < 8; c++) begin
      req_qin = {32'(300 + c), 32'(200 + c), 32'(100 + c), 32'(c)};
      tick();
    end
    idle(14);
    chk("fair grant count", 64'(grant_log.size()), 8);
    if (grant_log.size() == 8)
      for (int k = 0; k < 8; k++) chk("fair grant order", 64'(grant_log[k]), 64'(exp_g[k]));
    for (int r = 0; r < NR; r++) begin
      c0 = 0;
      foreach (grant_log[k]) if (grant_log[k] == r) c0++;
      chk("fair per-requester grants", 64'(c0), 2);
    end

    // Interleaved rows: r1 rows of 3, r2 rows of 2.
    sum_log.delete();
    i1 = 0; i2 = 0; cnt = 0;
    while ((i1 < 6 || i2 < 4) && cnt < 40) begin
      req_valid = {1'b0, i2 < 4, i1 < 6, 1'b0};
      req_last  = {1'b0, (i2 == 1 || i2 == 3), (i1 == 2 || i1 == 5), 1'b0};
      req_qin[32 +: 32] = 32'(q1[i1 % 6]);
      req_qin[64 +: 32] = 32'(q2[i2 % 4]);
      @(negedge clk);
      gseen = req_ready;
      tick();
      if (gseen[1]) i1++;
      if (gseen[2]) i2++;
      cnt++;
    end
    chk("interleave finished in budget", 64'(cnt < 40), 1);
    idle(14);
    s1.delete(); s2.delete();
    foreach (sum_log[k]) begin
      if (sum_log[k][49:48] == 2'd1) s1.push_back(sum_log[k][47:0]);
      if (sum_log[k][49:48] == 2'd2) s2.push_back(sum_log[k][47:0]);
    end
    chk("r1 sum count", 64'(s1.size()), 2);
    chk("r2 sum count", 64'(s2.size()), 2);
    if (s1.size() == 2) begin
      chk("r1 row0 sum", 64'(s1[0]), 64'd3221225532);
      chk("r1 row1 sum", 64'(s1[1]), 64'd3221225622);
    end
    if (s2.size() == 2) begin
      chk("r2 row0 sum", 64'(s2[0]), 64'd2147483650);
      chk("r2 row1 sum", 64'(s2[1]), 64'd2147483659);
    end

    // Bubbles: r3 valid on alternating cycles; busy falls 9 edges after the
    // final transfer edge (cycle t+10).
    req_last = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      req_valid = (k % 2 == 0) ? 4'b1000 : 4'b0000;
      req_qin[96 +: 32] = 32'(k * 3);
      tick();
    end
    req_valid = '0;
    cnt = 0;
    while (busy && cnt < 30) begin tick(); cnt++; end
    chk("busy drop edges", 64'(cnt), 64'(LAT + 1));
    idle(3);

    // Reset mid-row with 5 tags in flight.
    req_valid = 4'b0001; req_last = '0;
    for (int k = 0; k < 5; k++) begin
      req_qin[31:0] = 32'(k + 1);
      tick();
    end
    idle(2);
    chk("pre-reset busy", 64'(busy), 1);
    rst = 1'b0;
    #1;
    chk("rst exp_in_valid", 64'(exp_in_valid), 0);
    chk("rst busy", 64'(busy), 0);
    chk("rst rsp_valid", 64'(rsp_valid), 0);
    chk("rst sum_valid", 64'(sum_valid), 0);
    chk("rst rsp_data", 64'(rsp_data), 0);
    chk("rst sum_data", 64'(sum_data), 0);
    chk("rst exp_qin", 64'(exp_qin), 0);
    chk("rst rsp_last", 64'(rsp_last), 0);
    chk("rst tag_err", 64'(tag_err), 0);
    tick(); tick();
    rst = 1'b1;
    c0 = rsp_cnt;
    idle(15);
    chk("no rsp after reset", 64'(rsp_cnt - c0), 0);
    sum_log.delete();
    req_valid = 4'b0001;
    req_last = 4'b0000; req_qin[31:0] = 32'd1; tick();
    req_last = 4'b0001; req_qin[31:0] = 32'd2; tick();
    idle(14);
    chk("post-reset sum count", 64'(sum_log.size()), 1);
    if (sum_log.size() == 1) chk("post-reset sum", 64'(sum_log[0]), {14'd0, 2'd0, 48'd2147483651});

    // Error injection with an empty pipe.
    c0 = rsp_cnt;
    inj = 1'b1; tick(); inj = 1'b0;
    chk("tag_err set", 64'(tag_err), 1);
    idle(5);
    chk("tag_err sticky", 64'(tag_err), 1);
    chk("no rsp on error", 64'(rsp_cnt - c0), 0);
    rst = 1'b0;
    #1;
    chk("tag_err cleared by reset", 64'(tag_err), 0);
    tick();
    rst = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
